checkpoint_writer: RTL
======================

CHECKPOINT_WRITER -- requirements
Module: checkpoint_writer

Interface
REQ-001 Parameter DEPTH, default 4, journal entries (power of two, 2..16).
REQ-002 Parameter DATA_W, default 32, store address and data width.
REQ-003 clk  input  1  sole clock, rising-edge.
REQ-004 rst_in  input  1  reset, asynchronous, active-high.
REQ-005 MemWrite  input  1  voted store strobe, one store per cycle high.
REQ-006 ALUResult  input  DATA_W  voted store address.
REQ-007 RD2_Top  input  DATA_W  voted store data.
REQ-008 Voter_state  input  3  per-core disagreement flags; 3'b000 means unanimous.
REQ-009 Recovery_mode  input  1  lockstep recovery in progress.
REQ-010 commit  input  1  checkpoint boundary pulse.
REQ-011 rec_WE  output  1  Recovery_Register write enable.
REQ-012 rec_A  output  DATA_W  Recovery_Register write address.
REQ-013 rec_WD  output  DATA_W  Recovery_Register write data.
REQ-014 hold_req  output  1  core stall request, high when journal full.
REQ-015 journal_count  output  5  occupied entries, committed plus uncommitted.
REQ-016 overflow_err  output  1  sticky, store lost.
REQ-017 parity_err  output  1  sticky, corrupted entry suppressed.

Function
REQ-018 The journal is a circular FIFO with three pointers: wr_ptr, commit_ptr and rd_ptr.
- Entries in [rd_ptr, commit_ptr) are committed.
- Entries in [commit_ptr, wr_ptr) are speculative.
REQ-019 FSM states are RUN, ROLLBACK and HOLD.
REQ-020 In RUN, MemWrite=1 with the journal not full pushes {ALUResult, RD2_Top} at wr_ptr in the same cycle.
REQ-021 In RUN, commit=1 sets commit_ptr to wr_ptr, including any push made in the same cycle.
REQ-022 When committed entries exist in RUN, one entry drains per cycle.
- rec_WE=1, with rec_A and rec_WD taken from rd_ptr, registered, so there is 1-cycle latency from commit to the first write.
- rd_ptr advances on each drain.
REQ-023 Voter_state != 0 in RUN moves the FSM to ROLLBACK on the next edge, and that cycle's push is discarded.
REQ-024 ROLLBACK lasts exactly one cycle.
- wr_ptr is set to commit_ptr, so speculative entries are lost and committed entries are kept.
- rec_WE=0.
- Next state is HOLD if Recovery_mode=1, else RUN.
REQ-025 Recovery_mode=1 in any state moves the FSM to HOLD, with ROLLBACK taking precedence first.
- In HOLD there is no push, no drain, and rec_WE=0.
REQ-026 Recovery_mode=0 returns the FSM from HOLD to RUN.
REQ-027 Full is journal_count == DEPTH.
- hold_req=1 while full.
- MemWrite while full drops the store and sets overflow_err.
REQ-028 A push and a drain in the same cycle keep journal_count unchanged, and this SHALL be allowed when full.
REQ-029 commit and Voter_state != 0 in the same cycle: the mismatch wins, commit is ignored, and ROLLBACK follows.
REQ-030 Pointers SHALL wrap modulo DEPTH.
- An extra wrap bit distinguishes full from empty.
REQ-031 commit with no speculative entries is a no-op.

Reset
REQ-032 rst_in=1 asynchronously clears the following:
- all pointers;
- the FSM to RUN;
- rec_WE, rec_A, rec_WD, hold_req and journal_count to 0;
- overflow_err and parity_err to 0.
Journal storage contents are not reset.
REQ-033 Reset during a drain SHALL abort it and deassert rec_WE immediately.
- All entries are lost.

Configuration
REQ-034 Macro CKPT_PARITY_EN controls per-entry parity.
- Defined: each entry stores one even-parity bit over {address, data}, checked at drain. On a mismatch rec_WE=0 for that entry, rd_ptr still advances, and parity_err is set.
- Undefined: no parity bit is stored and parity_err is tied 0.

Structure
REQ-035 Shared package ckpt_pkg holds the FSM state encoding, the DEPTH default, and the Voter_state unanimous constant.
REQ-036 Sub-module ckpt_fifo holds storage and pointers and exposes push, commit, rollback and pop.
- checkpoint_writer holds the FSM and the output registers.

Verification
REQ-037 Stores (0x10, 0xA), (0x14, 0xB), then commit -> rec_WE high two consecutive cycles, starting one cycle after commit, with rec_A/rec_WD 0x10/0xA then 0x14/0xB.
REQ-038 Two stores, no commit, then Voter_state=3'b010 -> ROLLBACK for 1 cycle, journal_count=0, no rec_WE.
REQ-039 DEPTH=4: five stores without commit -> hold_req=1 after the fourth, the fifth is dropped, overflow_err=1, journal_count=4.
REQ-040 commit and Voter_state=3'b001 in the same cycle with 1 speculative entry -> the entry is discarded and no write occurs.
REQ-041 Recovery_mode=1 for 3 cycles with 2 committed entries -> no rec_WE during HOLD; the drain resumes on return to RUN.
REQ-042 With CKPT_PARITY_EN, force a stored data bit flip on a committed entry -> that entry is skipped and parity_err=1; rst_in pulse mid-drain -> all outputs are 0 asynchronously.

Source files
------------

// File: rtl/ckpt_pkg.sv
// Shared FSM encoding and constants for the checkpoint store journal.
package ckpt_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_ROLLBACK = 2'd1,
    ST_HOLD     = 2'd2
  } ckpt_state_t;

  localparam int unsigned CKPT_DEPTH_DEFAULT = 4;
  localparam logic [2:0]  VOTE_UNANIMOUS     = 3'b000;

endpackage

// File: rtl/ckpt_fifo.sv
// Circular store journal with write, commit and read pointers, each carrying a wrap bit.
// Optional feature: CKPT_PARITY_EN stores one even-parity bit per entry.
module ckpt_fifo
  import ckpt_pkg::*;
#(
  parameter int unsigned DEPTH  = CKPT_DEPTH_DEFAULT,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_addr,
  input  logic [DATA_W-1:0] push_data,
  input  logic              commit,
  input  logic              rollback,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_addr,
  output logic [DATA_W-1:0] pop_data,
  output logic              pop_ok,
  output logic [4:0]        count,
  output logic              full,
  output logic              avail
);

  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned AW = IW + 1;
`ifdef CKPT_PARITY_EN
  localparam int unsigned EW = 2 * DATA_W + 1;
`else
  localparam int unsigned EW = 2 * DATA_W;
`endif
  localparam logic [AW-1:0] PTR_ONE  = {{IW{1'b0}}, 1'b1};
  localparam logic [4:0]    FULL_CNT = 5'(DEPTH);

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] commit_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_next;
  logic [AW-1:0] ptr_diff;
  logic [EW-1:0] wr_entry;
  logic [EW-1:0] rd_entry;

  assign wr_next  = wr_ptr + PTR_ONE;
  assign ptr_diff = wr_ptr - rd_ptr;
  assign count    = 5'(ptr_diff);
  assign full     = (count == FULL_CNT);
  assign avail    = (rd_ptr != commit_ptr);

  assign rd_entry = mem[rd_ptr[IW-1:0]];
  assign pop_addr = rd_entry[2*DATA_W-1:DATA_W];
  assign pop_data = rd_entry[DATA_W-1:0];

`ifdef CKPT_PARITY_EN
  // Even parity: the XOR over the whole stored word is zero when intact.
  assign wr_entry = {^{push_addr, push_data}, push_addr, push_data};
  assign pop_ok   = ~(^rd_entry);
`else
  assign wr_entry = {push_addr, push_data};
  assign pop_ok   = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[IW-1:0]] <= wr_entry;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      commit_ptr <= '0;
      rd_ptr     <= '0;
    end else begin
      if (rollback) begin
        wr_ptr <= commit_ptr;
      end else if (push) begin
        wr_ptr <= wr_next;
      end
      // A commit covers a push made in the same cycle.
      if (commit) begin
        commit_ptr <= push ? wr_next : wr_ptr;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

endmodule

// File: rtl/checkpoint_writer.sv
// Journals voted stores, drains committed ones to the Recovery_Register, rolls back on mismatch.
// Optional feature: CKPT_PARITY_EN enables per-entry parity checking at drain.
module checkpoint_writer
  import ckpt_pkg::*;
#(
  parameter int unsigned DEPTH  = CKPT_DEPTH_DEFAULT,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_in,
  input  logic              MemWrite,
  input  logic [DATA_W-1:0] ALUResult,
  input  logic [DATA_W-1:0] RD2_Top,
  input  logic [2:0]        Voter_state,
  input  logic              Recovery_mode,
  input  logic              commit,
  output logic              rec_WE,
  output logic [DATA_W-1:0] rec_A,
  output logic [DATA_W-1:0] rec_WD,
  output logic              hold_req,
  output logic [4:0]        journal_count,
  output logic              overflow_err,
  output logic              parity_err
);

  ckpt_state_t       state;
  logic              mismatch;
  logic              in_run;
  logic              do_pop;
  logic              do_push;
  logic              do_commit;
  logic              do_rollback;
  logic              lost_store;
  logic [DATA_W-1:0] fifo_addr;
  logic [DATA_W-1:0] fifo_data;
  logic              fifo_ok;
  logic [4:0]        fifo_count;
  logic              fifo_full;
  logic              fifo_avail;

  ckpt_fifo #(
    .DEPTH (DEPTH),
    .DATA_W(DATA_W)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst_in),
    .push     (do_push),
    .push_addr(ALUResult),
    .push_data(RD2_Top),
    .commit   (do_commit),
    .rollback (do_rollback),
    .pop      (do_pop),
    .pop_addr (fifo_addr),
    .pop_data (fifo_data),
    .pop_ok   (fifo_ok),
    .count    (fifo_count),
    .full     (fifo_full),
    .avail    (fifo_avail)
  );

  // Drain pauses as soon as recovery is requested so HOLD never sees a write.
  // A drain frees a slot, so a store is accepted even while full.
  always_comb begin
    mismatch    = (Voter_state != VOTE_UNANIMOUS);
    in_run      = (state == ST_RUN);
    do_pop      = in_run && !Recovery_mode && fifo_avail;
    do_push     = in_run && MemWrite && !mismatch && (!fifo_full || do_pop);
    do_commit   = in_run && commit && !mismatch;
    do_rollback = (state == ST_ROLLBACK);
    lost_store  = in_run && MemWrite && !mismatch && fifo_full && !do_pop;
  end

  assign hold_req      = fifo_full;
  assign journal_count = fifo_count;

  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      state        <= ST_RUN;
      rec_WE       <= 1'b0;
      rec_A        <= '0;
      rec_WD       <= '0;
      overflow_err <= 1'b0;
`ifdef CKPT_PARITY_EN
      parity_err   <= 1'b0;
`endif
    end else begin
      rec_WE <= 1'b0;
      if (do_pop) begin
        rec_WE <= fifo_ok;
        rec_A  <= fifo_addr;
        rec_WD <= fifo_data;
`ifdef CKPT_PARITY_EN
        if (!fifo_ok) parity_err <= 1'b1;
`endif
      end
      if (lost_store) overflow_err <= 1'b1;
      case (state)
        ST_RUN: begin
          if (mismatch)           state <= ST_ROLLBACK;
          else if (Recovery_mode) state <= ST_HOLD;
        end
        ST_ROLLBACK: state <= Recovery_mode ? ST_HOLD : ST_RUN;
        ST_HOLD:     if (!Recovery_mode) state <= ST_RUN;
        default:     state <= ST_RUN;
      endcase
    end
  end

`ifndef CKPT_PARITY_EN
  assign parity_err = 1'b0;
`endif

endmodule
